// File: rtl/sram_multiport_arbiter.sv
// Arbitrates NCH read/write request channels onto one asynchronous SRAM.
// Channel 0 wins outright while rt_urgent is high; otherwise channels are served round-robin.
module sram_multiport_arbiter #(
  parameter int NCH        = 3,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_ready,
  input  logic              rt_urgent,
  output logic [NCH-1:0]    rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DW-1:0]     sram_dq_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [CW-1:0]   rr_q;
  logic [CW-1:0]   ch_q;
  logic            we_q;
  logic            rd_pend_q;
  logic [NCH-1:0]  req_ready_q;
  logic [NCH-1:0]  rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic [AW-1:0]   sram_addr_q;
  logic [DW-1:0]   sram_dq_out_q;
  logic            sram_dq_oe_q;
  logic            sram_cs_n_q;
  logic            sram_oe_n_q;
  logic            sram_we_n_q;

  logic            win_vld_d;
  logic            win_rr_d;
  logic [CW-1:0]   win_ch_d;
  logic [CW-1:0]   scan_ch;
  int              scan_idx;

  always_comb begin
    win_vld_d = 1'b0;
    win_rr_d  = 1'b0;
    win_ch_d  = '0;
    scan_idx  = 0;
    scan_ch   = '0;
    if (rt_urgent && req_valid[0]) begin
      win_vld_d = 1'b1;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        scan_idx = int'(rr_q) + k;
        if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
        scan_ch = CW'(scan_idx);
        if (!win_vld_d && req_valid[scan_ch]) begin
          win_vld_d = 1'b1;
          win_rr_d  = 1'b1;
          win_ch_d  = scan_ch;
        end
      end
    end
  end

  // Strobe registers trail the state by one cycle: the grant cycle itself shows
  // strobes idle, and the IDLE edge after a read is the one that samples the pad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_q          <= CW'(NCH - 1);
      ch_q          <= '0;
      we_q          <= 1'b0;
      rd_pend_q     <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_cs_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          sram_cs_n_q  <= 1'b1;
          sram_oe_n_q  <= 1'b1;
          sram_we_n_q  <= 1'b1;
          sram_dq_oe_q <= 1'b0;
          if (rd_pend_q) begin
            rsp_data_q         <= sram_dq_in;
            rsp_valid_q[ch_q]  <= 1'b1;
            rd_pend_q          <= 1'b0;
          end
          if (win_vld_d) begin
            req_ready_q[win_ch_d] <= 1'b1;
            sram_addr_q           <= req_addr[int'(win_ch_d)*AW +: AW];
            we_q                  <= req_we[win_ch_d];
            ch_q                  <= win_ch_d;
            if (req_we[win_ch_d]) sram_dq_out_q <= req_wdata[int'(win_ch_d)*DW +: DW];
            if (win_rr_d) rr_q <= win_ch_d;
            cnt_q   <= 3'(ACC_CYCLES - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          sram_cs_n_q  <= 1'b0;
          sram_we_n_q  <= !we_q;
          sram_oe_n_q  <= we_q;
          sram_dq_oe_q <= we_q;
          if (cnt_q == '0) begin
            if (we_q) begin
              state_q <= RECOVER;
            end else begin
              rd_pend_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RECOVER: begin
          // Data stays driven for hold time and turnaround.
          sram_cs_n_q <= 1'b1;
          sram_we_n_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_cs_n   = sram_cs_n_q;
  assign sram_oe_n   = sram_oe_n_q;
  assign sram_we_n   = sram_we_n_q;

endmodule
